// File: rtl/layer1_dense_mac_if.sv
// Bus between the layer-1 weight loader / activation source and the dense MAC stage.
// The master drives operands and start; the slave returns results and status.
interface layer1_dense_mac_if #(
  parameter int unsigned IN_SIZE  = 1152,
  parameter int unsigned OUT_SIZE = 8,
  parameter int unsigned W        = 8,
  parameter int unsigned ACC_W    = 32
);
  logic                           start;
  logic [IN_SIZE*OUT_SIZE*W-1:0]  weights;
  logic                           weights_valid;
  logic [IN_SIZE*W-1:0]           x_in;
  logic [OUT_SIZE*ACC_W-1:0]      bias;
  logic [OUT_SIZE*ACC_W-1:0]      y_out;
  logic                           busy;
  logic                           done;

  modport master (
    output start, weights, weights_valid, x_in, bias,
    input  y_out, busy, done
  );

  modport slave (
    input  start, weights, weights_valid, x_in, bias,
    output y_out, busy, done
  );
endinterface

// File: rtl/layer1_dense_mac.sv
// Layer-1 dense stage: streams one activation per cycle through OUT_SIZE MAC lanes,
// then adds bias, optionally applies ReLU and holds the registered result.
module layer1_dense_mac #(
  parameter int unsigned IN_SIZE  = 1152,
  parameter int unsigned OUT_SIZE = 8,
  parameter int unsigned W        = 8,
  parameter int unsigned ACC_W    = 32,
  parameter int unsigned RELU     = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  layer1_dense_mac_if.slave bus
);

  localparam int unsigned IW   = $clog2(IN_SIZE) + 1;
  localparam int unsigned PW   = 2 * W;
  localparam int unsigned XB_W = $clog2(IN_SIZE * W);
  localparam int unsigned WB_W = $clog2(IN_SIZE * OUT_SIZE * W);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_W, S_MAC, S_FLUSH, S_OUT, S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   idx_q;
  logic            flush_q;
  logic            prod_vld_q;
  logic            busy_q, done_q;
  logic            accept_c, issue_c, load_c;
  logic [XB_W-1:0] xbase_c;
  logic signed [W-1:0] x_sel_c;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; DONE restarts exactly like IDLE
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: if (bus.start) state_d = bus.weights_valid ? S_MAC : S_WAIT_W;
      S_WAIT_W:       if (bus.weights_valid) state_d = S_MAC;
      S_MAC:          if (idx_q == IW'(IN_SIZE)) state_d = S_FLUSH;
      S_FLUSH:        if (flush_q) state_d = S_OUT;
      S_OUT:          state_d = S_DONE;
      default:        state_d = S_IDLE;
    endcase
  end

  // Datapath strobes decoded from the current state
  always_comb begin
    accept_c = 1'b0;
    issue_c  = 1'b0;
    load_c   = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: accept_c = bus.start;
      S_MAC:          issue_c  = (idx_q != IW'(IN_SIZE));
      S_OUT:          load_c   = 1'b1;
      default:        ;
    endcase
  end

  // Index counter, flush counter and status flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q      <= '0;
      flush_q    <= 1'b0;
      prod_vld_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      if (accept_c)     idx_q <= '0;
      else if (issue_c) idx_q <= idx_q + IW'(1);
      flush_q    <= (state_q == S_FLUSH) ? ~flush_q : 1'b0;
      prod_vld_q <= issue_c;
      busy_q     <= (state_d != S_IDLE) && (state_d != S_DONE);
      done_q     <= (state_d == S_DONE);
    end
  end

  // Activation for the current index, shared by all lanes
  always_comb begin
    xbase_c = XB_W'(32'(idx_q) * W);
    x_sel_c = bus.x_in[xbase_c +: W];
  end

  for (genvar j = 0; j < OUT_SIZE; j++) begin : g_lane
    logic [WB_W-1:0]         wbase_c;
    logic signed [W-1:0]     w_sel_c;
    logic signed [PW-1:0]    prod_q;
    logic signed [ACC_W-1:0] acc_q;
    logic signed [ACC_W-1:0] r_c;
    logic [ACC_W-1:0]        y_q;

    always_comb begin
      wbase_c = WB_W'(j * IN_SIZE * W) + WB_W'(32'(idx_q) * W);
      w_sel_c = bus.weights[wbase_c +: W];
    end

    // Bias add wraps; ReLU clamps on the sign bit
    always_comb begin
      r_c = acc_q + $signed(bus.bias[j*ACC_W +: ACC_W]);
      if ((RELU != 0) && r_c[ACC_W-1]) r_c = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        prod_q <= '0;
        acc_q  <= '0;
        y_q    <= '0;
      end else begin
        if (issue_c)         prod_q <= PW'(x_sel_c) * PW'(w_sel_c);
        if (accept_c)        acc_q  <= '0;
        else if (prod_vld_q) acc_q  <= acc_q + ACC_W'(prod_q);
        if (load_c)          y_q    <= r_c;
      end
    end

    assign bus.y_out[j*ACC_W +: ACC_W] = y_q;
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;

endmodule

// File: tb/tb_layer1_dense_mac.sv
// Directed bench for layer1_dense_mac: small 4x2 instances (RELU off/on) and a
// default-size instance for full-length latency, reset and back-to-back runs.
module tb_layer1_dense_mac;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   n_chk = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  layer1_dense_mac_if #(.IN_SIZE(4), .OUT_SIZE(2), .W(8), .ACC_W(32)) bus_s0 ();
  layer1_dense_mac_if #(.IN_SIZE(4), .OUT_SIZE(2), .W(8), .ACC_W(32)) bus_s1 ();
  layer1_dense_mac_if #(.IN_SIZE(1152), .OUT_SIZE(8), .W(8), .ACC_W(32)) bus_b ();

  layer1_dense_mac #(.IN_SIZE(4), .OUT_SIZE(2), .W(8), .ACC_W(32), .RELU(0)) u_s0 (
    .clk(clk), .rst_n(rst_n), .bus(bus_s0.slave));
  layer1_dense_mac #(.IN_SIZE(4), .OUT_SIZE(2), .W(8), .ACC_W(32), .RELU(1)) u_s1 (
    .clk(clk), .rst_n(rst_n), .bus(bus_s1.slave));
  layer1_dense_mac #(.IN_SIZE(1152), .OUT_SIZE(8), .W(8), .ACC_W(32), .RELU(0)) u_b (
    .clk(clk), .rst_n(rst_n), .bus(bus_b.slave));

  // RELU instance sees exactly the same operands as the plain one
  assign bus_s1.start         = bus_s0.start;
  assign bus_s1.weights       = bus_s0.weights;
  assign bus_s1.weights_valid = bus_s0.weights_valid;
  assign bus_s1.x_in          = bus_s0.x_in;
  assign bus_s1.bias          = bus_s0.bias;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h)",
               tag, $signed(got), got, $signed(exp), exp);
    end
  endtask

  // Called 1 time unit after an edge; returns 1 time unit after the start edge
  task automatic pulse_s();
    bus_s0.start = 1'b1;
    @(posedge clk); #1;
    bus_s0.start = 1'b0;
  endtask

  task automatic pulse_b();
    bus_b.start = 1'b1;
    @(posedge clk); #1;
    bus_b.start = 1'b0;
  endtask

  // Count edges until done; optional stray start pulse at cycle pulse_at
  task automatic wait_s(input int lim, input int pulse_at, output int cyc, output int bcnt);
    cyc  = 0;
    bcnt = bus_s0.busy ? 1 : 0;
    while (!bus_s0.done && cyc < lim) begin
      bus_s0.start = (cyc == pulse_at);
      @(posedge clk); #1;
      cyc++;
      if (!bus_s0.done && bus_s0.busy) bcnt++;
    end
    bus_s0.start = 1'b0;
  endtask

  // Count edges until done, checking lane 0 holds its old value meanwhile
  task automatic wait_b(input int lim, input logic [31:0] hold, output int cyc, output bit held);
    cyc  = 0;
    held = 1'b1;
    while (!bus_b.done && cyc < lim) begin
      if (bus_b.y_out[31:0] !== hold) held = 1'b0;
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  int cyc, bcnt;
  bit held;

  initial begin
    bus_s0.start = 1'b0; bus_s0.weights_valid = 1'b0;
    bus_s0.x_in = '0; bus_s0.weights = '0; bus_s0.bias = '0;
    bus_b.start = 1'b0; bus_b.weights_valid = 1'b0;
    bus_b.x_in = '0; bus_b.weights = '0; bus_b.bias = '0;

    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_done_s", 32'(bus_s0.done), 32'd0);
    chk("reset_busy_s", 32'(bus_s0.busy), 32'd0);
    chk("reset_y_s", bus_s0.y_out[31:0], 32'd0);
    chk("reset_done_b", 32'(bus_b.done), 32'd0);
    chk("reset_busy_b", 32'(bus_b.busy), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // Small: x=[1,2,3,4], w0=[1,1,1,1], w1=[-1,0,0,2], bias 0
    bus_s0.x_in          = {8'd4, 8'd3, 8'd2, 8'd1};
    bus_s0.weights       = {8'd2, 8'd0, 8'd0, 8'hFF, 8'd1, 8'd1, 8'd1, 8'd1};
    bus_s0.weights_valid = 1'b1;
    pulse_s();
    wait_s(50, -1, cyc, bcnt);
    chk("small_latency", 32'(cyc), 32'd8);
    chk("small_busy_cycles", 32'(bcnt), 32'd8);
    chk("small_busy_at_done", 32'(bus_s0.busy), 32'd0);
    chk("small_y0", bus_s0.y_out[31:0], 32'd10);
    chk("small_y1", bus_s0.y_out[63:32], 32'd7);
    chk("small_relu_y0", bus_s1.y_out[31:0], 32'd10);
    chk("small_relu_y1", bus_s1.y_out[63:32], 32'd7);

    // Bias 100 / -20
    bus_s0.bias = {32'hFFFF_FFEC, 32'd100};
    pulse_s();
    wait_s(50, -1, cyc, bcnt);
    chk("bias_latency", 32'(cyc), 32'd8);
    chk("bias_y0", bus_s0.y_out[31:0], 32'd110);
    chk("bias_y1", bus_s0.y_out[63:32], 32'hFFFF_FFF3);
    chk("bias_relu_y0", bus_s1.y_out[31:0], 32'd110);
    chk("bias_relu_y1", bus_s1.y_out[63:32], 32'd0);

    // Weights late; x=[2,2,2,2] -> y0=108, y1=-18; stray start during MAC
    bus_s0.weights_valid = 1'b0;
    bus_s0.x_in          = {8'd2, 8'd2, 8'd2, 8'd2};
    pulse_s();
    chk("wait_busy_a", 32'(bus_s0.busy), 32'd1);
    chk("wait_done_a", 32'(bus_s0.done), 32'd0);
    repeat (10) begin @(posedge clk); #1; end
    chk("wait_busy_b", 32'(bus_s0.busy), 32'd1);
    chk("wait_done_b", 32'(bus_s0.done), 32'd0);
    bus_s0.weights_valid = 1'b1;
    @(posedge clk); #1;
    wait_s(50, 2, cyc, bcnt);
    chk("wait_latency", 32'(cyc), 32'd8);
    chk("wait_y0", bus_s0.y_out[31:0], 32'd108);
    chk("wait_y1", bus_s0.y_out[63:32], 32'hFFFF_FFEE);
    chk("wait_relu_y1", bus_s1.y_out[63:32], 32'd0);

    // Default size: all x=-128, w=-128
    bus_b.x_in          = {1152{8'h80}};
    bus_b.weights       = {9216{8'h80}};
    bus_b.weights_valid = 1'b1;
    pulse_b();
    wait_b(2000, 32'd0, cyc, held);
    chk("big_nn_latency", 32'(cyc), 32'd1156);
    chk("big_nn_hold", 32'(held), 32'd1);
    chk("big_nn_y0", bus_b.y_out[31:0], 32'd18874368);
    chk("big_nn_y7", bus_b.y_out[255:224], 32'd18874368);

    // w=127 -> -18726912
    bus_b.weights = {9216{8'h7F}};
    pulse_b();
    wait_b(2000, 32'd18874368, cyc, held);
    chk("big_np_latency", 32'(cyc), 32'd1156);
    chk("big_np_hold", 32'(held), 32'd1);
    chk("big_np_y0", bus_b.y_out[31:0], 32'(-18726912));
    chk("big_np_y7", bus_b.y_out[255:224], 32'(-18726912));

    // Start held in DONE with new x=1 -> 127*1152 = 146304
    bus_b.x_in  = {1152{8'h01}};
    bus_b.start = 1'b1;
    @(posedge clk); #1;
    chk("held_done_drop", 32'(bus_b.done), 32'd0);
    wait_b(2000, 32'(-18726912), cyc, held);
    bus_b.start = 1'b0;
    chk("held_latency", 32'(cyc), 32'd1156);
    chk("held_hold", 32'(held), 32'd1);
    chk("held_y0", bus_b.y_out[31:0], 32'd146304);
    chk("held_y5", bus_b.y_out[191:160], 32'd146304);
    @(posedge clk); #1;

    // Async reset mid-MAC at i=500
    pulse_b();
    repeat (500) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("midrst_y0", bus_b.y_out[31:0], 32'd0);
    chk("midrst_done", 32'(bus_b.done), 32'd0);
    chk("midrst_busy", 32'(bus_b.busy), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    bus_b.x_in    = {1152{8'h80}};
    bus_b.weights = {9216{8'h80}};
    pulse_b();
    wait_b(2000, 32'd0, cyc, held);
    chk("postrst_latency", 32'(cyc), 32'd1156);
    chk("postrst_hold", 32'(held), 32'd1);
    chk("postrst_y3", bus_b.y_out[127:96], 32'd18874368);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
